instr_mem_bridge: RTL and testbench

- Instruction-side memory responder that sits directly downstream of the core fetch port.
- Accepts one fetch address per ready/valid handshake and returns the instruction word after a fixed, parameterised latency.
- Holds the instruction image in an on-chip word array, which is loaded through a side programming port.
- Provides the instr_ready / instr_valid / instr handshake that the core fetch state machine consumes.

---
 rtl/instr_mem_bridge_pkg.sv | 18 +
 rtl/instr_mem_bridge_if.sv | 28 ++
 rtl/instr_mem_bridge_array.sv | 47 ++++
 rtl/instr_mem_bridge.sv | 131 +++++++++++++
 tb/tb_instr_mem_bridge.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_bridge_pkg.sv
// Shared constants for the instruction memory bridge: the NOP word returned
// on faulting fetches, the FSM state encodings and the default geometry.
package instr_mem_bridge_pkg;

    // addi x0, x0, 0 -- returned whenever a fetch faults and after reset
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Bridge FSM state encodings
    localparam logic [1:0] IMB_IDLE = 2'd0;
    localparam logic [1:0] IMB_BUSY = 2'd1;
    localparam logic [1:0] IMB_RESP = 2'd2;
    localparam logic [1:0] IMB_GAP  = 2'd3;

    // Default geometry
    localparam int unsigned IMB_DEF_LATENCY = 2;
    localparam int unsigned IMB_DEF_DEPTH   = 1024;

endpackage

// File: rtl/instr_mem_bridge_if.sv
// Fetch handshake plus side programming port between the core (master) and
// the instruction memory bridge (slave).
interface instr_mem_bridge_if;

    logic [31:0] instr_addr_in;
    logic        instr_addr_valid_in;
    logic        flush_in;
    logic        prog_we_in;
    logic [31:0] prog_addr_in;
    logic [31:0] prog_data_in;
    logic        instr_ready_out;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic        instr_err_out;

    modport master (
        output instr_addr_in, instr_addr_valid_in, flush_in,
               prog_we_in, prog_addr_in, prog_data_in,
        input  instr_ready_out, instr_valid_out, instr_out, instr_err_out
    );

    modport slave (
        input  instr_addr_in, instr_addr_valid_in, flush_in,
               prog_we_in, prog_addr_in, prog_data_in,
        output instr_ready_out, instr_valid_out, instr_out, instr_err_out
    );

endinterface

// File: rtl/instr_mem_bridge_array.sv
// DEPTH x 32 instruction word array: one write port, one registered read
// port. A read and write to the same index on one edge returns the old word.
// The read register doubles as the bridge's instruction output register, so
// it resets to NOP, can be forced to NOP, and otherwise holds its value.
module instr_mem_array
    import instr_mem_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = IMB_DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic          clr_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, sampling the pre-write contents of the array
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= INSTR_NOP;
        end else if (clr_i) begin
            rdata_q <= INSTR_NOP;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_bridge.sv
// Instruction-side memory responder: accepts one fetch per handshake, waits
// LATENCY cycles, returns the word (or NOP plus an error strobe), then holds
// ready low for one gap cycle so the core can update its fetch address.
module instr_mem_bridge
    import instr_mem_bridge_pkg::*;
#(
    parameter int unsigned DEPTH     = IMB_DEF_DEPTH,
    parameter int unsigned LATENCY   = IMB_DEF_LATENCY,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_mem_bridge_if.slave    bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic [31:0]   offset_s;
    logic          addr_err_s;
    logic          rd_en_s;
    logic          rd_clr_s;
    logic [31:0]   rdata_s;

    assign offset_s = addr_q - BASE_ADDR;

    // Fault decode: misaligned byte address or word index beyond the array
    always_comb begin
        if ((offset_s[1:0] != 2'b00) || (offset_s[31:AW+2] != {(30-AW){1'b0}})) begin
            addr_err_s = 1'b1;
        end else begin
            addr_err_s = 1'b0;
        end
    end

    // FSM next-state, latency countdown and response generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ready_d  = ready_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rd_en_s  = 1'b0;
        rd_clr_s = 1'b0;
        case (state_q)
            IMB_IDLE: begin
                if (bus.instr_addr_valid_in && !bus.flush_in) begin
                    addr_d  = bus.instr_addr_in;
                    cnt_d   = CNT_INIT;
                    ready_d = 1'b0;
                    state_d = IMB_BUSY;
                end else begin
                    state_d = IMB_IDLE;
                end
            end
            IMB_BUSY: begin
                if (bus.flush_in) begin
                    // Abandon the fetch; the output word is left untouched
                    state_d = IMB_GAP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = IMB_RESP;
                    valid_d  = 1'b1;
                    err_d    = addr_err_s;
                    rd_en_s  = !addr_err_s;
                    rd_clr_s = addr_err_s;
                end
            end
            IMB_RESP: begin
                state_d = IMB_GAP;
            end
            IMB_GAP: begin
                state_d = IMB_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IMB_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset overrides everything on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IMB_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0000_0000;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    instr_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.prog_we_in),
        .waddr_i (bus.prog_addr_in[AW-1:0]),
        .wdata_i (bus.prog_data_in),
        .re_i    (rd_en_s),
        .clr_i   (rd_clr_s),
        .raddr_i (offset_s[AW+1:2]),
        .rdata_o (rdata_s)
    );

    assign bus.instr_ready_out = ready_q;
    assign bus.instr_valid_out = valid_q;
    assign bus.instr_err_out   = err_q;
    assign bus.instr_out       = rdata_s;

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Self-checking bench for instr_mem_bridge: a transaction-timing reference
// model checks every output after every edge, with table-driven fetches,
// directed corner sequences and a randomized phase.
module tb_instr_mem_bridge;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, a_paddr, a_pdata;
    logic        a_valid, a_flush, a_we;

    always #5 clk = ~clk;

    instr_mem_bridge_if bus ();

    assign bus.instr_addr_in       = a_addr;
    assign bus.instr_addr_valid_in = a_valid;
    assign bus.flush_in            = a_flush;
    assign bus.prog_we_in          = a_we;
    assign bus.prog_addr_in        = a_paddr;
    assign bus.prog_data_in        = a_pdata;

    instr_mem_bridge #(
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a fetch accepted at edge a responds at edge a+LAT;
    // the next accept is possible at resp+3, or flush+2 after a flush.
    int          n = 0;
    bit          pend = 1'b0;
    int          acc_edge, resp_edge;
    int          free_edge = 0;
    logic [31:0] m_addr;
    logic        exp_valid = 1'b0, exp_err = 1'b0, exp_ready = 1'b1;
    logic [31:0] exp_instr = NOP_W;
    logic [31:0] mem_m [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_edge();
        logic [31:0] off;
        n++;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst) begin
            pend      = 1'b0;
            free_edge = n + 1;
            exp_instr = NOP_W;
            exp_ready = 1'b1;
        end else begin
            if (pend && a_flush && n > acc_edge) begin
                pend      = 1'b0;
                free_edge = n + 2;
            end else if (pend && n == resp_edge) begin
                pend      = 1'b0;
                exp_valid = 1'b1;
                off       = m_addr - BASE;
                if ((off % 4) != 0 || (off / 4) >= DEPTH) begin
                    exp_err   = 1'b1;
                    exp_instr = NOP_W;
                end else begin
                    exp_instr = mem_m[off / 4];
                end
                free_edge = n + 3;
            end
            if (!pend && n >= free_edge && a_valid && !a_flush) begin
                pend      = 1'b1;
                acc_edge  = n;
                resp_edge = n + LAT;
                m_addr    = a_addr;
            end
            exp_ready = !pend && (n + 1 >= free_edge);
        end
        if (a_we) mem_m[a_paddr % DEPTH] = a_pdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", {31'd0, bus.instr_valid_out}, {31'd0, exp_valid});
        chk("err",   {31'd0, bus.instr_err_out},   {31'd0, exp_err});
        chk("ready", {31'd0, bus.instr_ready_out}, {31'd0, exp_ready});
        chk("instr", bus.instr_out, exp_instr);
    endtask

    task automatic prog(input int idx, input logic [31:0] data);
        a_we = 1'b1; a_paddr = idx; a_pdata = data;
        tick();
        a_we = 1'b0;
    endtask

    // Raise a request and wait (bounded) until the bridge takes it
    task automatic wait_accept(input logic [31:0] addr);
        bit ok = 1'b0;
        a_addr = addr; a_valid = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            if (pend && acc_edge == n) ok = 1'b1;
        end
        a_valid = 1'b0;
        chk("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output bit got,
                            output logic [31:0] d, output logic e);
        got = 1'b0; d = 32'd0; e = 1'b0;
        a_addr = addr; a_valid = 1'b1;
        for (int i = 0; i < LAT + 12 && !got; i++) begin
            tick();
            if (pend && acc_edge == n) a_valid = 1'b0;
            if (bus.instr_valid_out === 1'b1) begin
                got = 1'b1; d = bus.instr_out; e = bus.instr_err_out;
            end
        end
        a_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          got, late;
        logic [31:0] d, prev;
        logic        e;
        int          r_edges [$];
        logic [31:0] r_data  [$];
        int          k;

        vecs[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0006, NOP_W,         1'b1};
        vecs[2] = '{32'h0000_1000, NOP_W,         1'b1};
        vecs[3] = '{32'h0000_0004, 32'hA5A5_0001, 1'b0};
        vecs[4] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, NOP_W,         1'b1};
        vecs[6] = '{32'h0000_001C, 32'hA5A5_0007, 1'b0};
        vecs[7] = '{32'h0000_0003, NOP_W,         1'b1};

        rst = 1'b1; a_addr = 32'd0; a_valid = 1'b0; a_flush = 1'b0;
        a_we = 1'b0; a_paddr = 32'd0; a_pdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        chk("rst_valid", {31'd0, bus.instr_valid_out}, 32'd0);
        chk("rst_instr", bus.instr_out, NOP_W);

        for (int i = 0; i < DEPTH; i++) prog(i, 32'hA5A5_0000 | i);
        prog(3, 32'hDEAD_BEEF);
        prog(1023, 32'hCAFE_F00D);

        // Table-driven fetches
        foreach (vecs[i]) begin
            do_fetch(vecs[i].addr, got, d, e);
            chk("tbl_resp_seen", {31'd0, got}, 32'd1);
            chk("tbl_data", d, vecs[i].data);
            chk("tbl_err", {31'd0, e}, {31'd0, vecs[i].err});
        end

        // Back-to-back: valid held high, addresses 0,4,8
        tick(); tick(); tick();
        k = 0; a_addr = 32'd0; a_valid = 1'b1;
        for (int i = 0; i < 40 && r_edges.size() < 3; i++) begin
            tick();
            if (pend && acc_edge == n) begin
                k++;
                a_addr = 4 * k;
                if (k == 3) a_valid = 1'b0;
            end
            if (bus.instr_valid_out === 1'b1) begin
                r_edges.push_back(n);
                r_data.push_back(bus.instr_out);
            end
        end
        a_valid = 1'b0;
        chk("b2b_count", r_edges.size(), 32'd3);
        if (r_edges.size() == 3) begin
            chk("b2b_gap01", r_edges[1] - r_edges[0], LAT + 3);
            chk("b2b_gap12", r_edges[2] - r_edges[1], LAT + 3);
            chk("b2b_d0", r_data[0], 32'hA5A5_0000);
            chk("b2b_d1", r_data[1], 32'hA5A5_0001);
            chk("b2b_d2", r_data[2], 32'hA5A5_0002);
        end

        // Flush one cycle after an accept
        tick(); tick(); tick();
        prev = bus.instr_out;
        wait_accept(32'h0000_001C);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("flush_no_valid", {31'd0, bus.instr_valid_out}, 32'd0);
        chk("flush_hold", bus.instr_out, prev);
        chk("flush_ready_gap", {31'd0, bus.instr_ready_out}, 32'd0);
        tick();
        chk("flush_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        late = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.instr_valid_out === 1'b1) late = 1'b1;
        end
        chk("flush_no_late", {31'd0, late}, 32'd0);
        do_fetch(32'h0000_000C, got, d, e);
        chk("flush_next", d, 32'hDEAD_BEEF);

        // Write collision on the read edge returns the old word
        tick(); tick(); tick();
        prog(5, 32'h1111_1111);
        tick(); tick();
        wait_accept(32'h0000_0014);
        for (int i = 0; i < LAT - 1; i++) tick();
        a_we = 1'b1; a_paddr = 32'd5; a_pdata = 32'h2222_2222;
        tick();
        a_we = 1'b0;
        chk("coll_valid", {31'd0, bus.instr_valid_out}, 32'd1);
        chk("coll_old", bus.instr_out, 32'h1111_1111);
        do_fetch(32'h0000_0014, got, d, e);
        chk("coll_new", d, 32'h2222_2222);

        // Reset while BUSY
        tick(); tick(); tick();
        wait_accept(32'h0000_000C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rbusy_valid", {31'd0, bus.instr_valid_out}, 32'd0);
        chk("rbusy_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        chk("rbusy_instr", bus.instr_out, NOP_W);
        late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.instr_valid_out === 1'b1) late = 1'b1;
        end
        chk("rbusy_no_late", {31'd0, late}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int sel;
            rst     = ($urandom_range(0, 149) == 0);
            a_flush = ($urandom_range(0, 9) == 0);
            a_valid = $urandom_range(0, 1);
            sel     = $urandom_range(0, 7);
            if (sel < 5)       a_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            else if (sel == 5) a_addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
            else if (sel == 6) a_addr = 32'h0000_1000 + 32'($urandom_range(0, 255));
            else               a_addr = $urandom;
            a_we    = !rst && ($urandom_range(0, 3) == 0);
            a_paddr = {$urandom} & 32'hFFFF_F00F;
            a_pdata = $urandom;
            tick();
        end
        rst = 1'b0; a_valid = 1'b0; a_flush = 1'b0; a_we = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
